// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter: FSM states,
// character code map and symbol lengths in Morse units.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_GAP
    } state_t;

    localparam logic [5:0] CH_A         = 6'd0;
    localparam logic [5:0] CH_0         = 6'd26;
    localparam logic [5:0] CH_SPACE     = 6'd36;
    localparam logic [5:0] CH_MAX_VALID = 6'd36;

    localparam logic [2:0] DOT_UNITS  = 3'd1;
    localparam logic [2:0] DASH_UNITS = 3'd3;

endpackage

// File: rtl/morse_if.sv
// Character handshake between the source (keypad/UART) and the transmitter.
interface morse_if;
    logic [5:0] char_in;
    logic       in_valid;
    logic       in_ready;

    modport master (output char_in, output in_valid, input in_ready);
    modport slave  (input char_in, input in_valid, output in_ready);
endinterface

// File: rtl/morse_rom.sv
// Combinational code table: character code -> symbol count and dash mask,
// bit i of sym_bits being the i-th symbol sent (1 = dash).
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0] char_in,
    output logic       valid,
    output logic [2:0] sym_cnt,
    output logic [4:0] sym_bits
);

    // pat holds the symbols as written, first symbol in bit sym_cnt-1
    logic [4:0] pat;

    always_comb begin
        {sym_cnt, pat} = {3'd0, 5'b00000};
        case (char_in)
            6'd0:  {sym_cnt, pat} = {3'd2, 5'b00001}; // A .-
            6'd1:  {sym_cnt, pat} = {3'd4, 5'b01000}; // B -...
            6'd2:  {sym_cnt, pat} = {3'd4, 5'b01010}; // C -.-.
            6'd3:  {sym_cnt, pat} = {3'd3, 5'b00100}; // D -..
            6'd4:  {sym_cnt, pat} = {3'd1, 5'b00000}; // E .
            6'd5:  {sym_cnt, pat} = {3'd4, 5'b00010}; // F ..-.
            6'd6:  {sym_cnt, pat} = {3'd3, 5'b00110}; // G --.
            6'd7:  {sym_cnt, pat} = {3'd4, 5'b00000}; // H ....
            6'd8:  {sym_cnt, pat} = {3'd2, 5'b00000}; // I ..
            6'd9:  {sym_cnt, pat} = {3'd4, 5'b00111}; // J .---
            6'd10: {sym_cnt, pat} = {3'd3, 5'b00101}; // K -.-
            6'd11: {sym_cnt, pat} = {3'd4, 5'b00100}; // L .-..
            6'd12: {sym_cnt, pat} = {3'd2, 5'b00011}; // M --
            6'd13: {sym_cnt, pat} = {3'd2, 5'b00010}; // N -.
            6'd14: {sym_cnt, pat} = {3'd3, 5'b00111}; // O ---
            6'd15: {sym_cnt, pat} = {3'd4, 5'b00110}; // P .--.
            6'd16: {sym_cnt, pat} = {3'd4, 5'b01101}; // Q --.-
            6'd17: {sym_cnt, pat} = {3'd3, 5'b00010}; // R .-.
            6'd18: {sym_cnt, pat} = {3'd3, 5'b00000}; // S ...
            6'd19: {sym_cnt, pat} = {3'd1, 5'b00001}; // T -
            6'd20: {sym_cnt, pat} = {3'd3, 5'b00001}; // U ..-
            6'd21: {sym_cnt, pat} = {3'd4, 5'b00001}; // V ...-
            6'd22: {sym_cnt, pat} = {3'd3, 5'b00011}; // W .--
            6'd23: {sym_cnt, pat} = {3'd4, 5'b01001}; // X -..-
            6'd24: {sym_cnt, pat} = {3'd4, 5'b01011}; // Y -.--
            6'd25: {sym_cnt, pat} = {3'd4, 5'b01100}; // Z --..
            6'd26: {sym_cnt, pat} = {3'd5, 5'b11111}; // 0
            6'd27: {sym_cnt, pat} = {3'd5, 5'b01111}; // 1
            6'd28: {sym_cnt, pat} = {3'd5, 5'b00111}; // 2
            6'd29: {sym_cnt, pat} = {3'd5, 5'b00011}; // 3
            6'd30: {sym_cnt, pat} = {3'd5, 5'b00001}; // 4
            6'd31: {sym_cnt, pat} = {3'd5, 5'b00000}; // 5
            6'd32: {sym_cnt, pat} = {3'd5, 5'b10000}; // 6
            6'd33: {sym_cnt, pat} = {3'd5, 5'b11000}; // 7
            6'd34: {sym_cnt, pat} = {3'd5, 5'b11100}; // 8
            6'd35: {sym_cnt, pat} = {3'd5, 5'b11110}; // 9
            default: {sym_cnt, pat} = {3'd0, 5'b00000};
        endcase
    end

    assign valid = (char_in <= CH_MAX_VALID);

    // Reverse the written order into first-sent-in-bit-0 order
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_bits
            assign sym_bits[gi] = (3'(gi) < sym_cnt) ? pat[3'(sym_cnt - 3'd1 - 3'(gi))] : 1'b0;
        end
    endgenerate

endmodule

// File: rtl/morse_tx.sv
// Sequential Morse transmitter: one character per handshake, drives a
// registered lamp output with unit-based dot/dash/gap timing.
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4,
    parameter int unsigned LETTER_GAP  = 3,
    parameter int unsigned WORD_GAP    = 7
) (
    input  logic     clk,
    input  logic     rst_n,
    morse_if.slave   in_if,
    input  logic     abort,
    output logic     light,
    output logic     busy,
    output logic     done,
    output logic     err
);

    localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cyc_cnt_reg;
    logic [2:0]    unit_cnt_reg;
    logic [2:0]    sym_cnt_reg, sym_cnt_next;
    logic [4:0]    sym_bits_reg, sym_bits_next;
    logic [2:0]    sym_idx_reg, sym_idx_next;
    logic [2:0]    gap_len_reg, gap_len_next;
    logic          light_reg, done_reg, err_reg;
    logic          done_next, err_next;

    logic          rom_valid;
    logic [2:0]    rom_cnt;
    logic [4:0]    rom_bits;
    logic          unit_tick, seg_end;
    logic [2:0]    seg_len;

    morse_rom u_rom (
        .char_in  (in_if.char_in),
        .valid    (rom_valid),
        .sym_cnt  (rom_cnt),
        .sym_bits (rom_bits)
    );

    assign unit_tick = (cyc_cnt_reg == CYC_LAST);

    always_comb begin
        seg_len = DOT_UNITS;
        case (state_reg)
            ST_MARK:  seg_len = sym_bits_reg[sym_idx_reg] ? DASH_UNITS : DOT_UNITS;
            ST_SPACE: seg_len = DOT_UNITS;
            ST_GAP:   seg_len = gap_len_reg;
            default:  seg_len = DOT_UNITS;
        endcase
    end

    assign seg_end = unit_tick && ((unit_cnt_reg + 3'd1) == seg_len);

    always_comb begin
        state_next    = state_reg;
        sym_cnt_next  = sym_cnt_reg;
        sym_bits_next = sym_bits_reg;
        sym_idx_next  = sym_idx_reg;
        gap_len_next  = gap_len_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_if.in_valid) begin
                    if (!rom_valid) begin
                        err_next  = 1'b1;
                        done_next = 1'b1;
                    end else if (in_if.char_in == CH_SPACE) begin
                        state_next   = ST_GAP;
                        gap_len_next = 3'(WORD_GAP);
                    end else begin
                        state_next    = ST_MARK;
                        sym_cnt_next  = rom_cnt;
                        sym_bits_next = rom_bits;
                        sym_idx_next  = 3'd0;
                    end
                end
            end
            ST_MARK: begin
                if (seg_end) begin
                    if ((sym_idx_reg + 3'd1) == sym_cnt_reg) begin
                        state_next   = ST_GAP;
                        gap_len_next = 3'(LETTER_GAP);
                    end else begin
                        state_next = ST_SPACE;
                    end
                end
            end
            ST_SPACE: begin
                if (seg_end) begin
                    state_next   = ST_MARK;
                    sym_idx_next = sym_idx_reg + 3'd1;
                end
            end
            ST_GAP: begin
                if (seg_end) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort beats everything else once a character is in flight
        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            sym_cnt_reg  <= 3'd0;
            sym_bits_reg <= 5'd0;
            sym_idx_reg  <= 3'd0;
            gap_len_reg  <= 3'd0;
            light_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sym_cnt_reg  <= sym_cnt_next;
            sym_bits_reg <= sym_bits_next;
            sym_idx_reg  <= sym_idx_next;
            gap_len_reg  <= gap_len_next;
            // Lamp follows the state being entered, so it rises on the accept edge
            light_reg    <= (state_next == ST_MARK);
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_reg  <= '0;
            unit_cnt_reg <= 3'd0;
        end else if ((state_next != state_reg) || (state_reg == ST_IDLE)) begin
            cyc_cnt_reg  <= '0;
            unit_cnt_reg <= 3'd0;
        end else if (unit_tick) begin
            cyc_cnt_reg  <= '0;
            unit_cnt_reg <= unit_cnt_reg + 3'd1;
        end else begin
            cyc_cnt_reg  <= cyc_cnt_reg + 1'b1;
        end
    end

    assign in_if.in_ready = (state_reg == ST_IDLE);
    assign busy           = (state_reg != ST_IDLE);
    assign light          = light_reg;
    assign done           = done_reg;
    assign err            = err_reg;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx: lamp traces built from hand-written dot/dash
// strings, handshake timing, invalid codes, abort and asynchronous reset.
module tb_morse_tx;

    localparam int U = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic light, busy, done, err;
    int   n_checks = 0;
    int   n_fail   = 0;

    morse_if in_if ();

    morse_tx #(.UNIT_CYCLES(U), .LETTER_GAP(3), .WORD_GAP(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_if (in_if),
        .abort (abort),
        .light (light),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Sends one character and follows it to its done cycle. pat is the Morse
    // string ("" = word space). With hold set, in_valid stays high carrying
    // next_code while busy, so the next call is accepted in the done cycle.
    task automatic tx_char(input string tag, input logic [5:0] code, input string pat,
                           input bit hold, input logic [5:0] next_code);
        logic [127:0] exp_tr = '0;
        logic [127:0] obs_tr = '0;
        int pos = 0;
        int busy_bad = 0;
        int done_early = 0;
        if (pat.len() == 0) begin
            pos = 7 * U;
        end else begin
            for (int i = 0; i < pat.len(); i++) begin
                int n = (pat[i] == 8'h2d) ? 3 * U : U;
                for (int j = 0; j < n; j++) exp_tr[pos + j] = 1'b1;
                pos += n;
                if (i != pat.len() - 1) pos += U;
            end
            pos += 3 * U;
        end
        in_if.char_in  = code;
        in_if.in_valid = 1'b1;
        check_eq({tag, " in_ready before accept"}, 128'(in_if.in_ready), 128'd1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        if (hold) in_if.char_in = next_code;
        else      in_if.in_valid = 1'b0;
        for (int k = 1; k <= pos + 1; k++) begin
            @(negedge clk);
            if (k <= pos) begin
                obs_tr[k - 1] = light;
                if (busy !== 1'b1 || in_if.in_ready !== 1'b0) busy_bad++;
                if (done !== 1'b0) done_early++;
            end
        end
        check_eq({tag, " light trace"}, obs_tr, exp_tr);
        check_eq({tag, " busy/ready while sending"}, 128'(busy_bad), 128'd0);
        check_eq({tag, " premature done"}, 128'(done_early), 128'd0);
        check_eq({tag, " done at end"}, 128'(done), 128'd1);
        check_eq({tag, " in_ready at end"}, 128'(in_if.in_ready), 128'd1);
        check_eq({tag, " err at end"}, 128'(err), 128'd0);
        $display("char %s code %0d: %0d busy cycles, done on cycle %0d", tag, code, pos, pos + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        in_if.char_in  = 6'd0;
        in_if.in_valid = 1'b0;
        #2;
        check_eq("reset light", 128'(light), 128'd0);
        check_eq("reset busy", 128'(busy), 128'd0);
        check_eq("reset done", 128'(done), 128'd0);
        check_eq("reset err", 128'(err), 128'd0);
        check_eq("reset in_ready", 128'(in_if.in_ready), 128'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        tx_char("E", 6'd4, ".", 1'b0, 6'd0);
        @(negedge clk);
        tx_char("A", 6'd0, ".-", 1'b0, 6'd0);
        @(negedge clk);
        tx_char("0", 6'd26, "-----", 1'b0, 6'd0);
        @(negedge clk);
        tx_char("Q", 6'd16, "--.-", 1'b0, 6'd0);
        @(negedge clk);
        tx_char("7", 6'd33, "--...", 1'b0, 6'd0);
        @(negedge clk);
        tx_char("space", 6'd36, "", 1'b0, 6'd0);

        // Invalid code straight after the space's done cycle
        in_if.char_in  = 6'd50;
        in_if.in_valid = 1'b1;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        @(negedge clk);
        check_eq("invalid err pulse", 128'(err), 128'd1);
        check_eq("invalid done pulse", 128'(done), 128'd1);
        check_eq("invalid busy", 128'(busy), 128'd0);
        check_eq("invalid light", 128'(light), 128'd0);
        @(negedge clk);
        check_eq("invalid err cleared", 128'(err), 128'd0);
        check_eq("invalid done cleared", 128'(done), 128'd0);
        $display("char invalid code 50: err pulse");

        // Back-to-back E then T, in_valid held high throughout E
        tx_char("E held", 6'd4, ".", 1'b1, 6'd19);
        tx_char("T chained", 6'd19, "-", 1'b0, 6'd0);

        // Abort asserted in IDLE must not block the accept
        @(negedge clk);
        abort = 1'b1;
        tx_char("E abort-idle", 6'd4, ".", 1'b0, 6'd0);

        // Abort in the middle of B's opening dash
        @(negedge clk);
        in_if.char_in  = 6'd1;
        in_if.in_valid = 1'b1;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("B mid-dash light", 128'(light), 128'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_eq("abort light", 128'(light), 128'd0);
        check_eq("abort busy", 128'(busy), 128'd0);
        check_eq("abort in_ready", 128'(in_if.in_ready), 128'd1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || light !== 1'b0) cnt++;
            @(negedge clk);
        end
        check_eq("abort no done/light after", 128'(cnt), 128'd0);
        $display("char B code 1: aborted mid-dash");

        // Asynchronous reset in the middle of A's first dot
        in_if.char_in  = 6'd0;
        in_if.in_valid = 1'b1;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("A before reset busy", 128'(busy), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async reset light", 128'(light), 128'd0);
        check_eq("async reset busy", 128'(busy), 128'd0);
        check_eq("async reset in_ready", 128'(in_if.in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || light !== 1'b0 || busy !== 1'b0) cnt++;
            @(negedge clk);
        end
        check_eq("reset drops character silently", 128'(cnt), 128'd0);
        $display("char A code 0: dropped by reset");

        // Transmitter must be usable again after reset
        tx_char("N after reset", 6'd13, "-.", 1'b0, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
